// File: rtl/spram_bist.sv
// -----------------------------------------------------------------------------
// spram_bist -- March-style built-in self test for a 1024 x 16 single-port RAM.
//
// A test writes a seeded pattern P(a) = {6'b0, a} ^ seed to every address
// (ascending), reads every address back (ascending) and compares each read
// word one cycle after the read is issued. A one-cycle DRAIN state finishes
// the last compare, then DONE pulses out_done and publishes out_pass.
//
// Optional feature (macro SPRAM_BIST_INVERT_PASS_EN): after the first read
// pass, a second write pass stores ~P(a) and a second read pass checks it.
//
// Ports:
//   in_clock          rising-edge clock
//   in_reset          asynchronous active-high reset (forces IDLE, outputs 0)
//   in_start          start request, honoured only in IDLE
//   in_seed[15:0]     pattern seed, latched when the start is accepted
//   out_mem_enable    RAM access strobe
//   out_mem_write     1 = write, 0 = read
//   out_mem_address   RAM word address [9:0]
//   out_mem_data      RAM write data [15:0]
//   in_mem_data       RAM read data, valid the cycle after a read
//   out_busy          test in progress
//   out_done          one-cycle completion pulse
//   out_pass          last completed test had no mismatches
//   out_fail_address  address of the first mismatch [9:0]
//   out_error_count   mismatch count, saturating at 2047 [10:0]
// -----------------------------------------------------------------------------
module spram_bist (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        in_start,
    input  logic [15:0] in_seed,
    output logic        out_mem_enable,
    output logic        out_mem_write,
    output logic [9:0]  out_mem_address,
    output logic [15:0] out_mem_data,
    input  logic [15:0] in_mem_data,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_pass,
    output logic [9:0]  out_fail_address,
    output logic [10:0] out_error_count
);

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 11;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
`ifdef SPRAM_BIST_INVERT_PASS_EN
        WRITE_INV = 3'd3,
        READ_INV  = 3'd4,
`endif
        DRAIN     = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr, addr_next;
    logic [DATA_W-1:0]   seed, seed_next;

    logic                mem_enable_next, mem_write_next;
    logic [ADDR_W-1:0]   mem_address_next;
    logic [DATA_W-1:0]   mem_data_next;
    logic [DATA_W-1:0]   pattern_next;
    logic                is_read_next;

    // Expected word for the read currently on the RAM port (_p0) and the
    // delayed compare slot that lines up with in_mem_data (_p1).
    logic [DATA_W-1:0]   exp_p0, exp_next;
    logic                cmp_vld_p1;
    logic [ADDR_W-1:0]   cmp_addr_p1;
    logic [DATA_W-1:0]   cmp_exp_p1;

    logic                start_accept;
    logic                mismatch;
    logic [CNT_W-1:0]    error_count_next;
    logic [ADDR_W-1:0]   fail_address_next;
    logic                pass_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
        return {{(DATA_W-ADDR_W){1'b0}}, a} ^ s;
    endfunction

    // State and address sequencing
    always_comb begin
        state_next   = state;
        addr_next    = addr;
        seed_next    = seed;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (in_start) begin
                    start_accept = 1'b1;
                    state_next   = WRITE;
                    addr_next    = '0;
                    seed_next    = in_seed;
                end
            end
            WRITE: begin
                addr_next = addr + 1'b1;
                if (addr == LAST_ADDR) state_next = READ;
            end
            READ: begin
                addr_next = addr + 1'b1;
`ifdef SPRAM_BIST_INVERT_PASS_EN
                if (addr == LAST_ADDR) state_next = WRITE_INV;
`else
                if (addr == LAST_ADDR) state_next = DRAIN;
`endif
            end
`ifdef SPRAM_BIST_INVERT_PASS_EN
            WRITE_INV: begin
                addr_next = addr + 1'b1;
                if (addr == LAST_ADDR) state_next = READ_INV;
            end
            READ_INV: begin
                addr_next = addr + 1'b1;
                if (addr == LAST_ADDR) state_next = DRAIN;
            end
`endif
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next state/address.
    always_comb begin
        mem_enable_next  = 1'b0;
        mem_write_next   = 1'b0;
        mem_address_next = '0;
        mem_data_next    = '0;
        is_read_next     = 1'b0;
        pattern_next     = pattern(addr_next, seed_next);
        exp_next         = pattern_next;
        case (state_next)
            WRITE: begin
                mem_enable_next  = 1'b1;
                mem_write_next   = 1'b1;
                mem_address_next = addr_next;
                mem_data_next    = pattern_next;
            end
            READ: begin
                mem_enable_next  = 1'b1;
                mem_address_next = addr_next;
                is_read_next     = 1'b1;
            end
`ifdef SPRAM_BIST_INVERT_PASS_EN
            WRITE_INV: begin
                mem_enable_next  = 1'b1;
                mem_write_next   = 1'b1;
                mem_address_next = addr_next;
                mem_data_next    = ~pattern_next;
            end
            READ_INV: begin
                mem_enable_next  = 1'b1;
                mem_address_next = addr_next;
                is_read_next     = 1'b1;
                exp_next         = ~pattern_next;
            end
`endif
            default: ;
        endcase
    end

    // Compare and result bookkeeping
    always_comb begin
        mismatch          = cmp_vld_p1 && (in_mem_data != cmp_exp_p1);
        error_count_next  = out_error_count;
        fail_address_next = out_fail_address;
        pass_next         = out_pass;
        if (start_accept) begin
            error_count_next  = '0;
            fail_address_next = '0;
            pass_next         = 1'b0;
        end else if (mismatch) begin
            error_count_next = sat_inc(out_error_count);
            // Count cannot return to zero once incremented, so zero marks the first.
            if (out_error_count == '0) fail_address_next = cmp_addr_p1;
        end
        // Includes the compare retiring on the same edge (DRAIN -> DONE).
        if (state_next == DONE) pass_next = (error_count_next == '0);
    end

    // Stage p0: state, RAM command and expected word for the issued read
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state            <= IDLE;
            addr             <= '0;
            seed             <= '0;
            out_mem_enable   <= 1'b0;
            out_mem_write    <= 1'b0;
            out_mem_address  <= '0;
            out_mem_data     <= '0;
            exp_p0           <= '0;
            out_busy         <= 1'b0;
            out_done         <= 1'b0;
            out_pass         <= 1'b0;
            out_fail_address <= '0;
            out_error_count  <= '0;
        end else begin
            state            <= state_next;
            addr             <= addr_next;
            seed             <= seed_next;
            out_mem_enable   <= mem_enable_next;
            out_mem_write    <= mem_write_next;
            out_mem_address  <= mem_address_next;
            out_mem_data     <= mem_data_next;
            exp_p0           <= is_read_next ? exp_next : '0;
            out_busy         <= (state_next != IDLE) && (state_next != DONE);
            out_done         <= (state_next == DONE);
            out_pass         <= pass_next;
            out_fail_address <= fail_address_next;
            out_error_count  <= error_count_next;
        end
    end

    // Stage p1: compare slot aligned with the RAM read data
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            cmp_vld_p1  <= 1'b0;
            cmp_addr_p1 <= '0;
            cmp_exp_p1  <= '0;
        end else begin
            cmp_vld_p1  <= out_mem_enable && !out_mem_write;
            cmp_addr_p1 <= out_mem_address;
            cmp_exp_p1  <= exp_p0;
        end
    end

endmodule

// File: tb/tb_spram_bist.sv
module tb_spram_bist;

`ifdef SPRAM_BIST_INVERT_PASS_EN
    localparam int DONE_CYC = 4098;
`else
    localparam int DONE_CYC = 2050;
`endif

    logic        in_clock = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_start = 1'b0;
    logic [15:0] in_seed  = 16'h0000;
    logic        out_mem_enable, out_mem_write;
    logic [9:0]  out_mem_address;
    logic [15:0] out_mem_data;
    logic [15:0] in_mem_data;
    logic        out_busy, out_done, out_pass;
    logic [9:0]  out_fail_address;
    logic [10:0] out_error_count;

    int n_assert = 0;
    int n_fail   = 0;

    // 0 none, 1 bit3 stuck-1 @0x155, 2 data forced 0xFFFF, 3 bit0 stuck-0 @0x000
    int fault_mode = 0;

    logic [15:0] mem [1024];
    logic [15:0] rd;
    logic [9:0]  rd_addr;

    int first_done, done_cnt;
    logic [31:0] snap1, snap1025, busy_pre, busy_done;

    always #5 in_clock = ~in_clock;

    spram_bist dut (
        .in_clock         (in_clock),
        .in_reset         (in_reset),
        .in_start         (in_start),
        .in_seed          (in_seed),
        .out_mem_enable   (out_mem_enable),
        .out_mem_write    (out_mem_write),
        .out_mem_address  (out_mem_address),
        .out_mem_data     (out_mem_data),
        .in_mem_data      (in_mem_data),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_pass         (out_pass),
        .out_fail_address (out_fail_address),
        .out_error_count  (out_error_count)
    );

    // Synchronous-read RAM model: data appears the cycle after a read.
    always @(posedge in_clock) begin
        if (out_mem_enable) begin
            if (out_mem_write) mem[out_mem_address] <= out_mem_data;
            else begin
                rd      <= mem[out_mem_address];
                rd_addr <= out_mem_address;
            end
        end
    end

    always_comb begin
        in_mem_data = rd;
        case (fault_mode)
            1: if (rd_addr == 10'h155) in_mem_data = rd | 16'h0008;
            2: in_mem_data = 16'hFFFF;
            3: if (rd_addr == 10'h000) in_mem_data = rd & 16'hFFFE;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {out_mem_enable, out_mem_write, out_mem_address, out_mem_data,
                out_busy, out_done, out_pass} | {out_fail_address, out_error_count};
    endfunction

    // Starts a test, then observes cycles 1..ncyc (sampled 1 time unit after each edge).
    task automatic run(input logic [15:0] seed, input int pulse_at, input int reset_at,
                       input int ncyc);
        first_done = 0;
        done_cnt   = 0;
        @(negedge in_clock);
        in_seed  = seed;
        in_start = 1'b1;
        @(posedge in_clock);
        #1;
        in_start = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            if (n > 1) begin
                @(posedge in_clock);
                #1;
            end
            in_start = (n == pulse_at);
            if (n == 1)
                snap1 = {out_mem_enable, out_mem_write, out_busy, out_mem_address, out_mem_data};
            if (n == 1025)
                snap1025 = {out_mem_enable, out_mem_write, out_busy, out_mem_address, out_mem_data};
            if (n == DONE_CYC - 1) busy_pre = {31'd0, out_busy};
            if (n == DONE_CYC) busy_done = {31'd0, out_busy};
            if (n == reset_at) begin
                in_reset = 1'b1;
                #1;
                check("async_reset_outputs", all_outputs(), 32'd0);
                check("async_reset_count", {21'd0, out_error_count}, 32'd0);
                #1;
                in_reset = 1'b0;
            end
            if (out_done) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
            end
        end
        in_start = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_outputs", all_outputs(), 32'd0);
        check("reset_count", {21'd0, out_error_count}, 32'd0);
        @(negedge in_clock);
        in_reset = 1'b0;

        // Fault-free, seed 0
        fault_mode = 0;
        run(16'h0000, 0, 0, DONE_CYC + 4);
        check("clean_done_cycle", first_done, DONE_CYC);
        check("clean_done_count", done_cnt, 1);
        check("clean_pass", {31'd0, out_pass}, 32'd1);
        check("clean_errcnt", {21'd0, out_error_count}, 32'd0);
        check("clean_first_write", snap1, {3'b111, 10'h000, 16'h0000});
        check("clean_first_read", snap1025, {3'b101, 10'h000, 16'h0000});
        check("clean_busy_before_done", busy_pre, 32'd1);
        check("clean_busy_in_done", busy_done, 32'd0);
        check("idle_ram_quiet", {out_mem_enable, out_mem_write, out_mem_address, out_mem_data}, 32'd0);

        // Bit 3 stuck-at-1 at 0x155, seed 0xA5A5
        fault_mode = 1;
        run(16'hA5A5, 0, 0, DONE_CYC + 4);
        check("stuck1_done_cycle", first_done, DONE_CYC);
        check("stuck1_first_write_data", snap1, {3'b111, 10'h000, 16'hA5A5});
        check("stuck1_pass", {31'd0, out_pass}, 32'd0);
        check("stuck1_fail_addr", {22'd0, out_fail_address}, 32'h155);
        check("stuck1_errcnt", {21'd0, out_error_count}, 32'd1);
        repeat (5) @(posedge in_clock);
        #1;
        check("hold_fail_addr", {22'd0, out_fail_address}, 32'h155);
        check("hold_errcnt", {21'd0, out_error_count}, 32'd1);
        check("hold_pass", {31'd0, out_pass}, 32'd0);

        // Read data forced to 0xFFFF, seed 0
        fault_mode = 2;
        run(16'h0000, 0, 0, DONE_CYC + 4);
        check("ones_pass", {31'd0, out_pass}, 32'd0);
        check("ones_fail_addr", {22'd0, out_fail_address}, 32'h000);
`ifdef SPRAM_BIST_INVERT_PASS_EN
        check("ones_errcnt", {21'd0, out_error_count}, 32'd2047);
`else
        check("ones_errcnt", {21'd0, out_error_count}, 32'd1024);
`endif

        // Reset at cycle 500, then a fresh run
        fault_mode = 0;
        run(16'h0000, 0, 500, DONE_CYC + 4);
        check("aborted_done_count", done_cnt, 0);
        check("aborted_busy", {31'd0, out_busy}, 32'd0);
        run(16'h1234, 0, 0, DONE_CYC + 4);
        check("after_abort_done_cycle", first_done, DONE_CYC);
        check("after_abort_pass", {31'd0, out_pass}, 32'd1);
        check("start_clears_results", {21'd0, out_error_count}, 32'd0);

        // Start re-pulsed at cycle 100 must be ignored
        run(16'h0000, 100, 0, DONE_CYC + 20);
        check("repulse_done_cycle", first_done, DONE_CYC);
        check("repulse_done_count", done_cnt, 1);
        check("repulse_idle", {31'd0, out_busy}, 32'd0);

        // Bit 0 stuck-at-0 at 0x000, seed 0
        fault_mode = 3;
        run(16'h0000, 0, 0, DONE_CYC + 4);
        check("stuck0_done_cycle", first_done, DONE_CYC);
`ifdef SPRAM_BIST_INVERT_PASS_EN
        check("stuck0_pass", {31'd0, out_pass}, 32'd0);
        check("stuck0_fail_addr", {22'd0, out_fail_address}, 32'h000);
        check("stuck0_errcnt", {21'd0, out_error_count}, 32'd1);
`else
        check("stuck0_pass", {31'd0, out_pass}, 32'd1);
        check("stuck0_errcnt", {21'd0, out_error_count}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
